// File: rtl/vram_dma_if.sv
// Bus bundle between the CPU/memory side and the VRAM DMA engine.
// No latency of its own; pure wiring.
// No backpressure: strobes are qualified by ce on both sides.
interface vram_dma_if;
    logic        ce;
    logic        reg_we;
    logic [2:0]  reg_addr;
    logic [7:0]  reg_din;
    logic [7:0]  reg_dout;
    logic [15:0] src_addr;
    logic        src_rd;
    logic [7:0]  src_data;
    logic [12:0] vram_addr;
    logic [7:0]  vram_din;
    logic        vram_we;
    logic        busy;

    // System side: CPU decoder, memory read port, VRAM consumer.
    modport master (
        output ce, reg_we, reg_addr, reg_din, src_data,
        input  reg_dout, src_addr, src_rd, vram_addr, vram_din, vram_we, busy
    );

    // DMA engine side.
    modport slave (
        input  ce, reg_we, reg_addr, reg_din, src_data,
        output reg_dout, src_addr, src_rd, vram_addr, vram_din, vram_we, busy
    );
endinterface

// File: rtl/vram_dma.sv
// Block copy from CPU address space into 8 KB VRAM, programmed via six byte registers.
// Latency: first vram_we 2 ce cycles after the start write; 2 ce cycles per byte.
// No backpressure: the CPU is halted via busy; strobes are valid only with ce=1.
module vram_dma #(
    parameter int BLOCK_SHIFT = 4
) (
    input  logic       clk,
    input  logic       reset,
    vram_dma_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state;
    logic [15:0] src;
    logic [15:0] dst;
    logic [7:0]  len;
    logic [12:0] count;
    logic [7:0]  din_q;
    logic [12:0] blocks;
    logic        start;

    // A zero length register means the maximum of 256 blocks.
    assign blocks = (len == 8'd0) ? 13'd256 : {5'd0, len};
    assign start  = bus.reg_we && (state == IDLE) && (bus.reg_addr == 3'd5) && bus.reg_din[7];

    // Register file, address/count stepping and transfer sequencing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            src   <= 16'd0;
            dst   <= 16'd0;
            len   <= 8'd0;
            count <= 13'd0;
            din_q <= 8'd0;
        end else if (bus.ce) begin
            case (state)
                IDLE: begin
                    if (bus.reg_we) begin
                        case (bus.reg_addr)
                            3'd0:    src[7:0]  <= bus.reg_din;
                            3'd1:    src[15:8] <= bus.reg_din;
                            3'd2:    dst[7:0]  <= bus.reg_din;
                            3'd3:    dst[15:8] <= bus.reg_din;
                            3'd4:    len       <= bus.reg_din;
                            default: ;
                        endcase
                    end
                    if (start) begin
                        count <= blocks << BLOCK_SHIFT;
                        state <= READ;
                    end
                end
                READ: state <= WRITE;
                WRITE: begin
                    din_q <= bus.src_data;
                    src   <= src + 16'd1;
                    dst   <= dst + 16'd1;
                    count <= count - 13'd1;
                    state <= (count == 13'd1) ? DONE : READ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes follow the state and are gated by ce so they never fire on idle cycles.
    always_comb begin
        bus.busy      = (state == READ) || (state == WRITE);
        bus.src_rd    = bus.ce && (state == READ);
        bus.vram_we   = bus.ce && (state == WRITE);
        bus.src_addr  = src;
        bus.vram_addr = dst[12:0];
        // Read data arrives during WRITE; pass it straight through, then hold it.
        bus.vram_din  = (state == WRITE) ? bus.src_data : din_q;
    end

    // Register readback; ctrl exposes only the busy flag.
    always_comb begin
        bus.reg_dout = 8'h00;
        case (bus.reg_addr)
            3'd0:    bus.reg_dout = src[7:0];
            3'd1:    bus.reg_dout = src[15:8];
            3'd2:    bus.reg_dout = dst[7:0];
            3'd3:    bus.reg_dout = dst[15:8];
            3'd4:    bus.reg_dout = len;
            3'd5:    bus.reg_dout = {bus.busy, 7'd0};
            default: bus.reg_dout = 8'h00;
        endcase
    end
endmodule
